// File: rtl/ipf_unit.sv
// rtl/ipf_unit.sv - eight-lane signed pixel x Q1.7 weight product unit with four-deep result stacking
module ipf_unit #(
   parameter int In_Width   = 8,
   parameter int Out_Width  = 9,
   parameter int Addr_Width = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [1:0]                      ctrl,
   input  logic                            i_valid,
   input  logic [8*In_Width-1:0]           i_data,
   input  logic                            w_valid,
   input  logic [8*In_Width-1:0]           w_data,
   input  logic [1:0]                      Wsize,
   input  logic [1:0]                      RLPadding,
   input  logic                            stride,
   input  logic [3:0]                      wgroup,
   input  logic [2:0]                      wround,
   output logic                            res_valid,
   output logic [4*32*8*Out_Width-1:0]     result,
   output logic                            finish,
   output logic [8*Out_Width-1:0]          tmp_result0,
   output logic [8*Out_Width-1:0]          tmp_result1,
   output logic [8*Out_Width-1:0]          tmp_result2,
   output logic [8*Out_Width-1:0]          tmp_result3,
   output logic [8*Out_Width-1:0]          tmp_result4,
   output logic [8*Out_Width-1:0]          tmp_result5,
   output logic [8*Out_Width-1:0]          tmp_result6,
   output logic [8*Out_Width-1:0]          tmp_result7,
   output logic [8*Out_Width-1:0]          tmp_result8,
   output logic [8*Out_Width-1:0]          tmp_result9,
   output logic [8*Out_Width-1:0]          tmp_result10,
   output logic [8*Out_Width-1:0]          tmp_result11,
   output logic [8*Out_Width-1:0]          tmp_result12,
   output logic [8*Out_Width-1:0]          tmp_result13,
   output logic [8*Out_Width-1:0]          tmp_result14,
   output logic [8*Out_Width-1:0]          tmp_result15,
   output logic [8*Out_Width-1:0]          tmp_result16,
   output logic [8*Out_Width-1:0]          tmp_result17,
   output logic [8*Out_Width-1:0]          tmp_result18,
   output logic [8*Out_Width-1:0]          tmp_result19,
   output logic [8*Out_Width-1:0]          tmp_result20,
   output logic [8*Out_Width-1:0]          tmp_result21,
   output logic [8*Out_Width-1:0]          tmp_result22,
   output logic [8*Out_Width-1:0]          tmp_result23,
   output logic [8*Out_Width-1:0]          tmp_result24,
   output logic [8*Out_Width-1:0]          tmp_result25,
   output logic [8*Out_Width-1:0]          tmp_result26,
   output logic [8*Out_Width-1:0]          tmp_result27,
   output logic [8*Out_Width-1:0]          tmp_result28,
   output logic [8*Out_Width-1:0]          tmp_result29,
   output logic [8*Out_Width-1:0]          tmp_result30,
   output logic [8*Out_Width-1:0]          tmp_result31
);
   localparam int Word_Width = 8*In_Width;
   localparam int Lane_Bus   = 8*Out_Width;
   localparam int Tmp_Bus    = 32*Lane_Bus;
   localparam int W_Depth    = 25;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]                   state;
   logic [Addr_Width-1:0]        wa;
   logic [Addr_Width-1:0]        w_limit;
   logic [2:0]                   wp;
   logic [1:0]                   cnt;
   logic [Word_Width-1:0]        wbuf [W_Depth];
   logic [Word_Width-1:0]        ibuf [8];
   logic [31:0][Lane_Bus-1:0]    tmp_q;
   logic [31:0][Lane_Bus-1:0]    tmp_d;
   logic [3:0][Word_Width-1:0]   w_sel;
   logic [3:0]                   w_ok;
   logic [7:0]                   lane_en;
   logic [7:0]                   base;
   logic                         compute;
   logic                         w_wr;
   logic                         i_wr;

   assign w_limit = (Wsize == 2'd0) ? Addr_Width'(18) : Addr_Width'(W_Depth);
   assign w_wr    = w_valid && (wa < w_limit);
   assign i_wr    = i_valid && (state != S_DONE);
   assign compute = (ctrl == 2'd1) && i_valid && (state != S_DONE);
   assign finish  = (state == S_DONE);
   assign base    = 8'({wround, 2'b00}) + 8'(wgroup) * 8'd9;

   always_comb begin
      for (int j = 0; j < 8; j++) begin
         lane_en[j] = !(stride && j[0]);
      end
      if (RLPadding[1]) lane_en[0] = 1'b0;
      if (RLPadding[0]) lane_en[7] = 1'b0;
   end

   // Group g reads weight word base+g; words past the buffer end yield zero lanes.
   for (genvar g = 0; g < 4; g++) begin : g_grp
      logic [7:0] idx;
      assign idx      = base + 8'(g);
      assign w_ok[g]  = (idx < 8'(W_Depth));
      assign w_sel[g] = wbuf[idx[4:0]];
      for (genvar r = 0; r < 8; r++) begin : g_row
         for (genvar j = 0; j < 8; j++) begin : g_lane
            logic signed [2*In_Width-1:0] prod;
            assign prod = $signed(ibuf[r][In_Width*j +: In_Width])
                        * $signed(w_sel[g][In_Width*j +: In_Width]);
            assign tmp_d[8*g+r][Out_Width*j +: Out_Width] =
               (w_ok[g] && lane_en[j]) ? prod[In_Width-1 +: Out_Width] : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && w_wr) wbuf[wa[4:0]] <= w_data;
      if (rst && i_wr) ibuf[wp] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         wa        <= '0;
         wp        <= '0;
         cnt       <= '0;
         tmp_q     <= '0;
         result    <= '0;
         res_valid <= 1'b0;
      end else begin
         res_valid <= compute && (cnt == 2'd3);
         if (w_wr) wa <= wa + Addr_Width'(1);
         if (i_wr) wp <= wp + 3'd1;
         if (compute) begin
            tmp_q  <= tmp_d;
            result <= {result[3*Tmp_Bus-1:0], tmp_d};
            cnt    <= cnt + 2'd1;
         end
         case (state)
            S_IDLE: if (ctrl == 2'd1) state <= S_RUN;
            S_RUN: begin
               if (ctrl == 2'd0) state <= S_DONE;
               else if (ctrl != 2'd1) state <= S_HOLD;
            end
            S_HOLD: begin
               if (ctrl == 2'd0) state <= S_DONE;
               else if (ctrl == 2'd1) state <= S_RUN;
            end
            default: state <= S_DONE;
         endcase
      end
   end

   assign tmp_result0  = tmp_q[0];
   assign tmp_result1  = tmp_q[1];
   assign tmp_result2  = tmp_q[2];
   assign tmp_result3  = tmp_q[3];
   assign tmp_result4  = tmp_q[4];
   assign tmp_result5  = tmp_q[5];
   assign tmp_result6  = tmp_q[6];
   assign tmp_result7  = tmp_q[7];
   assign tmp_result8  = tmp_q[8];
   assign tmp_result9  = tmp_q[9];
   assign tmp_result10 = tmp_q[10];
   assign tmp_result11 = tmp_q[11];
   assign tmp_result12 = tmp_q[12];
   assign tmp_result13 = tmp_q[13];
   assign tmp_result14 = tmp_q[14];
   assign tmp_result15 = tmp_q[15];
   assign tmp_result16 = tmp_q[16];
   assign tmp_result17 = tmp_q[17];
   assign tmp_result18 = tmp_q[18];
   assign tmp_result19 = tmp_q[19];
   assign tmp_result20 = tmp_q[20];
   assign tmp_result21 = tmp_q[21];
   assign tmp_result22 = tmp_q[22];
   assign tmp_result23 = tmp_q[23];
   assign tmp_result24 = tmp_q[24];
   assign tmp_result25 = tmp_q[25];
   assign tmp_result26 = tmp_q[26];
   assign tmp_result27 = tmp_q[27];
   assign tmp_result28 = tmp_q[28];
   assign tmp_result29 = tmp_q[29];
   assign tmp_result30 = tmp_q[30];
   assign tmp_result31 = tmp_q[31];
endmodule

// File: tb/tb_ipf_unit.sv
// tb/tb_ipf_unit.sv - table-driven bench for ipf_unit
module tb_ipf_unit;
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    ctrl = 2'd0;
   logic          i_valid = 1'b0;
   logic [63:0]   i_data = '0;
   logic          w_valid = 1'b0;
   logic [63:0]   w_data = '0;
   logic [1:0]    Wsize = 2'd0;
   logic [1:0]    RLPadding = 2'd0;
   logic          stride = 1'b0;
   logic [3:0]    wgroup = 4'd0;
   logic [2:0]    wround = 3'd0;
   logic          res_valid;
   logic [9215:0] result;
   logic          finish;
   logic [71:0]   tmp_r [32];

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ipf_unit dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .i_valid(i_valid), .i_data(i_data),
      .w_valid(w_valid), .w_data(w_data), .Wsize(Wsize), .RLPadding(RLPadding),
      .stride(stride), .wgroup(wgroup), .wround(wround),
      .res_valid(res_valid), .result(result), .finish(finish),
      .tmp_result0(tmp_r[0]),   .tmp_result1(tmp_r[1]),   .tmp_result2(tmp_r[2]),   .tmp_result3(tmp_r[3]),
      .tmp_result4(tmp_r[4]),   .tmp_result5(tmp_r[5]),   .tmp_result6(tmp_r[6]),   .tmp_result7(tmp_r[7]),
      .tmp_result8(tmp_r[8]),   .tmp_result9(tmp_r[9]),   .tmp_result10(tmp_r[10]), .tmp_result11(tmp_r[11]),
      .tmp_result12(tmp_r[12]), .tmp_result13(tmp_r[13]), .tmp_result14(tmp_r[14]), .tmp_result15(tmp_r[15]),
      .tmp_result16(tmp_r[16]), .tmp_result17(tmp_r[17]), .tmp_result18(tmp_r[18]), .tmp_result19(tmp_r[19]),
      .tmp_result20(tmp_r[20]), .tmp_result21(tmp_r[21]), .tmp_result22(tmp_r[22]), .tmp_result23(tmp_r[23]),
      .tmp_result24(tmp_r[24]), .tmp_result25(tmp_r[25]), .tmp_result26(tmp_r[26]), .tmp_result27(tmp_r[27]),
      .tmp_result28(tmp_r[28]), .tmp_result29(tmp_r[29]), .tmp_result30(tmp_r[30]), .tmp_result31(tmp_r[31])
   );

   typedef struct {
      logic        pr;
      logic [7:0]  pb;
      logic        wr;
      logic [7:0]  wb;
      logic        st;
      logic [1:0]  pd;
      logic [3:0]  gp;
      logic [2:0]  rd;
      logic [71:0] e0;
      logic [71:0] e10;
      logic [71:0] e31;
   } vec_t;

   vec_t vecs [13];

   function automatic logic [71:0] rep(input logic [8:0] v, input logic [7:0] m);
      logic [71:0] r;
      r = '0;
      for (int j = 0; j < 8; j++) if (m[j]) r[9*j +: 9] = v;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b0; ctrl = 2'd0; i_valid = 1'b0; w_valid = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic load_w(input logic ramp, input logic [7:0] b, input logic [1:0] ws, input int n);
      Wsize = ws;
      for (int i = 0; i < n; i++) begin
         w_valid = 1'b1;
         w_data  = {8{ramp ? 8'(i + 1) : b}};
         step();
      end
      w_valid = 1'b0;
   endtask

   task automatic load_i(input logic ramp, input logic [7:0] b);
      ctrl = 2'd0;
      for (int i = 0; i < 8; i++) begin
         i_valid = 1'b1;
         i_data  = {8{ramp ? 8'(i + 1) : b}};
         step();
      end
      i_valid = 1'b0;
   endtask

   task automatic compute(input logic st, input logic [1:0] pd, input logic [3:0] gp,
                          input logic [2:0] rd, input logic [63:0] d);
      stride = st; RLPadding = pd; wgroup = gp; wround = rd;
      ctrl = 2'd1; i_valid = 1'b1; i_data = d;
      step();
      i_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 8'h01, 1'b0, 8'h7F, 1'b0, 2'b00, 4'd0, 3'd0, rep(9'h000, 8'hFF), rep(9'h000, 8'hFF), rep(9'h000, 8'hFF)};
      vecs[1]  = '{1'b0, 8'h40, 1'b0, 8'h7F, 1'b0, 2'b00, 4'd0, 3'd0, rep(9'h03F, 8'hFF), rep(9'h03F, 8'hFF), rep(9'h03F, 8'hFF)};
      vecs[2]  = '{1'b0, 8'h80, 1'b0, 8'h80, 1'b0, 2'b00, 4'd0, 3'd0, rep(9'h080, 8'hFF), rep(9'h080, 8'hFF), rep(9'h080, 8'hFF)};
      vecs[3]  = '{1'b0, 8'h80, 1'b0, 8'h7F, 1'b0, 2'b00, 4'd0, 3'd0, rep(9'h181, 8'hFF), rep(9'h181, 8'hFF), rep(9'h181, 8'hFF)};
      vecs[4]  = '{1'b0, 8'hFF, 1'b0, 8'h7F, 1'b0, 2'b00, 4'd0, 3'd0, rep(9'h1FF, 8'hFF), rep(9'h1FF, 8'hFF), rep(9'h1FF, 8'hFF)};
      vecs[5]  = '{1'b0, 8'h80, 1'b0, 8'h80, 1'b1, 2'b11, 4'd0, 3'd0, rep(9'h080, 8'h54), rep(9'h080, 8'h54), rep(9'h080, 8'h54)};
      vecs[6]  = '{1'b0, 8'h40, 1'b0, 8'h7F, 1'b0, 2'b10, 4'd0, 3'd0, rep(9'h03F, 8'hFE), rep(9'h03F, 8'hFE), rep(9'h03F, 8'hFE)};
      vecs[7]  = '{1'b0, 8'h40, 1'b0, 8'h7F, 1'b0, 2'b01, 4'd0, 3'd0, rep(9'h03F, 8'h7F), rep(9'h03F, 8'h7F), rep(9'h03F, 8'h7F)};
      vecs[8]  = '{1'b0, 8'h40, 1'b0, 8'h7F, 1'b0, 2'b00, 4'd3, 3'd0, rep(9'h000, 8'hFF), rep(9'h000, 8'hFF), rep(9'h000, 8'hFF)};
      vecs[9]  = '{1'b1, 8'h00, 1'b0, 8'h7F, 1'b0, 2'b00, 4'd0, 3'd0, rep(9'd0, 8'hFF), rep(9'd2, 8'hFF), rep(9'd7, 8'hFF)};
      vecs[10] = '{1'b0, 8'h7F, 1'b1, 8'h00, 1'b0, 2'b00, 4'd0, 3'd0, rep(9'd0, 8'hFF), rep(9'd1, 8'hFF), rep(9'd3, 8'hFF)};
      vecs[11] = '{1'b0, 8'h7F, 1'b1, 8'h00, 1'b0, 2'b00, 4'd1, 3'd3, rep(9'd21, 8'hFF), rep(9'd22, 8'hFF), rep(9'd24, 8'hFF)};
      vecs[12] = '{1'b0, 8'h7F, 1'b1, 8'h00, 1'b0, 2'b00, 4'd2, 3'd1, rep(9'd22, 8'hFF), rep(9'd23, 8'hFF), rep(9'd0, 8'hFF)};

      step();
      step();
      rst = 1'b1;
      check("reset_finish", {71'b0, finish}, '0);
      check("reset_res_valid", {71'b0, res_valid}, '0);
      check("reset_result", {71'b0, |result}, '0);
      check("reset_tmp0", tmp_r[0], '0);
      check("reset_tmp31", tmp_r[31], '0);

      for (int i = 0; i < 13; i++) begin
         do_reset();
         load_w(vecs[i].wr, vecs[i].wb, 2'd1, 25);
         load_i(vecs[i].pr, vecs[i].pb);
         compute(vecs[i].st, vecs[i].pd, vecs[i].gp, vecs[i].rd, '0);
         check($sformatf("vec%0d_tmp0", i), tmp_r[0], vecs[i].e0);
         check($sformatf("vec%0d_tmp10", i), tmp_r[10], vecs[i].e10);
         check($sformatf("vec%0d_tmp31", i), tmp_r[31], vecs[i].e31);
      end

      // Words 18..24 still hold the ramp from the last vector; 3x3 loads must not overwrite them.
      do_reset();
      load_w(1'b0, 8'h7F, 2'd0, 25);
      load_i(1'b0, 8'h7F);
      compute(1'b0, 2'b00, 4'd2, 3'd0, {8{8'h7F}});
      check("limit_tmp0", tmp_r[0], rep(9'd18, 8'hFF));
      check("limit_tmp8", tmp_r[8], rep(9'd19, 8'hFF));
      check("limit_tmp31", tmp_r[31], rep(9'd21, 8'hFF));
      compute(1'b0, 2'b00, 4'd1, 3'd2, {8{8'h7F}});
      check("limit_w17", tmp_r[0], rep(9'h07E, 8'hFF));
      check("limit_w18", tmp_r[8], rep(9'd18, 8'hFF));

      do_reset();
      load_w(1'b0, 8'h7F, 2'd1, 25);
      load_i(1'b0, 8'h40);
      for (int c = 0; c < 4; c++) begin
         compute(1'b0, 2'b00, 4'd0, 3'd0, {8{8'h80}});
         if (c == 0) check("frame_first_tmp0", tmp_r[0], rep(9'h03F, 8'hFF));
         check($sformatf("frame_rv_c%0d", c), {71'b0, res_valid}, {71'b0, c == 3});
      end
      check("frame_latest_tmp0", result[71:0], rep(9'h181, 8'hFF));
      check("frame_latest_tmp31", result[2303:2232], rep(9'h03F, 8'hFF));
      check("frame_second_tmp0", result[4679:4608], rep(9'h181, 8'hFF));
      check("frame_second_tmp1", result[4751:4680], rep(9'h03F, 8'hFF));
      check("frame_first_slot0", result[6983:6912], rep(9'h03F, 8'hFF));
      check("frame_first_slot31", result[9215:9144], rep(9'h03F, 8'hFF));
      check("frame_tmp2", tmp_r[2], rep(9'h181, 8'hFF));
      check("frame_tmp3", tmp_r[3], rep(9'h03F, 8'hFF));

      for (int i = 0; i < 10; i++) begin
         ctrl    = (i < 5) ? 2'd2 : 2'd3;
         i_valid = 1'b1;
         i_data  = (i == 9) ? {8{8'h40}} : {8{8'h7F}};
         step();
         if (i == 0) check("hold_rv_clear", {71'b0, res_valid}, '0);
      end
      i_valid = 1'b0;
      check("hold_tmp0", tmp_r[0], rep(9'h181, 8'hFF));
      check("hold_result_lo", result[71:0], rep(9'h181, 8'hFF));
      check("hold_result_hi", result[6983:6912], rep(9'h03F, 8'hFF));

      compute(1'b0, 2'b00, 4'd0, 3'd0, '0);
      check("resume_tmp5", tmp_r[5], rep(9'h03F, 8'hFF));
      check("resume_tmp4", tmp_r[4], rep(9'h07E, 8'hFF));
      check("resume_tmp0", tmp_r[0], rep(9'h07E, 8'hFF));
      check("resume_rv", {71'b0, res_valid}, '0);

      ctrl = 2'd0;
      step();
      check("done_finish", {71'b0, finish}, {71'b0, 1'b1});
      ctrl = 2'd1; i_valid = 1'b1; i_data = {8{8'h80}};
      step();
      step();
      i_valid = 1'b0;
      check("done_finish_sticky", {71'b0, finish}, {71'b0, 1'b1});
      check("done_tmp5_frozen", tmp_r[5], rep(9'h03F, 8'hFF));
      check("done_rv", {71'b0, res_valid}, '0);
      rst = 1'b0; ctrl = 2'd0;
      step();
      rst = 1'b1;
      check("rst_finish", {71'b0, finish}, '0);
      check("rst_tmp5", tmp_r[5], '0);
      check("rst_result", {71'b0, |result}, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
